// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register map, STATUS bit positions and TX FSM states for the UART MMIO bridge
package uart_pkg;

  // Register byte offsets on the 4-bit bus address
  localparam logic [3:0] ADDR_TXDATA = 4'h0;
  localparam logic [3:0] ADDR_RXDATA = 4'h4;
  localparam logic [3:0] ADDR_STATUS = 4'h8;
  localparam logic [3:0] ADDR_BAUD   = 4'hC;

  // STATUS bit indices
  localparam int ST_TX_FULL     = 0;
  localparam int ST_TX_EMPTY    = 1;
  localparam int ST_RX_NONEMPTY = 2;
  localparam int ST_RX_FULL     = 3;
  localparam int ST_OVERRUN     = 4;
  localparam int ST_TX_DROP     = 5;
  localparam int ST_TX_IDLE     = 6;
  localparam int ST_RX_IE       = 8;
  localparam int ST_TX_IE       = 9;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with extra-MSB pointers, pop-before-push when full
// Ports:
//   clk, rst        clock, synchronous active-high reset (pointers only)
//   i_push, i_data  write strobe and data
//   i_pop           read strobe; ignored when empty
//   o_full, o_empty occupancy flags
//   o_head          oldest entry (valid when !o_empty)
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  // A pop frees a slot in the same cycle, so a push into a full FIFO that is
  // also being popped is accepted. Empty FIFOs never bypass: the pop is
  // gated on the pre-push state.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/uart_mmio_bridge.sv
// rtl/uart_mmio_bridge.sv - CPU register front end for the UART core: TX/RX FIFOs, launch FSM, RX ack, baud
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   bus_req/we/addr/wdata            single-cycle memory bus access
//   bus_rdata, bus_rvalid            registered read response, one cycle after req
//   uart_we, uart_tx_data, uart_busy TX handshake with the core
//   uart_read_ready, uart_rx_data    RX byte from the core
//   uart_negate_rr                   one-cycle RX acknowledge to the core
//   uart_baud_max                    clk cycles per bit for the core
//   irq                              level interrupt
module uart_mmio_bridge
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [15:0] BAUD_DEFAULT = 16'd234
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_rvalid,
  output logic        uart_we,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_busy,
  input  logic        uart_read_ready,
  input  logic [7:0]  uart_rx_data,
  output logic        uart_negate_rr,
  output logic [15:0] uart_baud_max,
  output logic        irq
);

  tx_state_e   r_state;
  tx_state_e   w_state_nxt;
  logic        w_launch;

  logic        r_uart_we;
  logic [7:0]  r_tx_data;
  logic        r_negate_rr;
  logic        r_ack_pending;
  logic        r_overrun;
  logic        r_tx_drop;
  logic        r_rx_ie;
  logic        r_tx_ie;
  logic [15:0] r_baud;
  logic [31:0] r_rdata;
  logic        r_rvalid;

  logic        w_wr;
  logic        w_rd;
  logic        w_tx_push;
  logic        w_rx_pop;
  logic        w_st_wr;
  logic        w_rx_capture;
  logic        w_tx_full;
  logic        w_tx_empty;
  logic [7:0]  w_tx_head;
  logic        w_rx_full;
  logic        w_rx_empty;
  logic [7:0]  w_rx_head;
  logic [31:0] w_status;
  logic [31:0] w_rd_val;
  logic        w_unused;

  assign w_wr      = bus_req & bus_we;
  assign w_rd      = bus_req & ~bus_we;
  assign w_tx_push = w_wr && (bus_addr == ADDR_TXDATA);
  assign w_rx_pop  = w_rd && (bus_addr == ADDR_RXDATA);
  assign w_st_wr   = w_wr && (bus_addr == ADDR_STATUS);
  assign w_unused  = ^bus_wdata[31:16];

  // Capture each core byte once: ack_pending blocks re-capture until the
  // core has dropped read_ready in response to negate_rr.
  assign w_rx_capture = uart_read_ready & ~r_ack_pending;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_tx_push),
    .i_data  (bus_wdata[7:0]),
    .i_pop   (w_launch),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_head  (w_tx_head)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rx_capture),
    .i_data  (uart_rx_data),
    .i_pop   (w_rx_pop),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_head  (w_rx_head)
  );

  // TX launch FSM
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_tx_empty && !uart_busy) begin
          w_launch    = 1'b1;
          w_state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: if (uart_busy)  w_state_nxt = WAIT_DONE;
      WAIT_DONE: if (!uart_busy) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_uart_we <= 1'b0;
      r_tx_data <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_uart_we <= w_launch;
      if (w_launch) r_tx_data <= w_tx_head;
    end
  end

  // RX acknowledge and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack_pending <= 1'b0;
      r_negate_rr   <= 1'b0;
      r_overrun     <= 1'b0;
      r_tx_drop     <= 1'b0;
      r_rx_ie       <= 1'b0;
      r_tx_ie       <= 1'b0;
      r_baud        <= BAUD_DEFAULT;
    end else begin
      r_negate_rr <= w_rx_capture;
      if (w_rx_capture)          r_ack_pending <= 1'b1;
      else if (!uart_read_ready) r_ack_pending <= 1'b0;

      // A new error event in the same cycle as a W1C keeps the flag set.
      if (w_rx_capture && w_rx_full && !w_rx_pop)
        r_overrun <= 1'b1;
      else if (w_st_wr && bus_wdata[ST_OVERRUN])
        r_overrun <= 1'b0;

      if (w_tx_push && w_tx_full && !w_launch)
        r_tx_drop <= 1'b1;
      else if (w_st_wr && bus_wdata[ST_TX_DROP])
        r_tx_drop <= 1'b0;

      if (w_st_wr) begin
        r_rx_ie <= bus_wdata[ST_RX_IE];
        r_tx_ie <= bus_wdata[ST_TX_IE];
      end

      if (w_wr && (bus_addr == ADDR_BAUD) && (bus_wdata[15:0] != 16'h0000))
        r_baud <= bus_wdata[15:0];
    end
  end

  always_comb begin
    w_status                 = 32'h0;
    w_status[ST_TX_FULL]     = w_tx_full;
    w_status[ST_TX_EMPTY]    = w_tx_empty;
    w_status[ST_RX_NONEMPTY] = ~w_rx_empty;
    w_status[ST_RX_FULL]     = w_rx_full;
    w_status[ST_OVERRUN]     = r_overrun;
    w_status[ST_TX_DROP]     = r_tx_drop;
    w_status[ST_TX_IDLE]     = w_tx_empty && (r_state == IDLE);
    w_status[ST_RX_IE]       = r_rx_ie;
    w_status[ST_TX_IE]       = r_tx_ie;
  end

  always_comb begin
    w_rd_val = 32'h0;
    case (bus_addr)
      ADDR_RXDATA: w_rd_val = w_rx_empty ? 32'h0 : {24'h0, w_rx_head};
      ADDR_STATUS: w_rd_val = w_status;
      ADDR_BAUD:   w_rd_val = {16'h0, r_baud};
      default:     w_rd_val = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata  <= 32'h0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      r_rdata  <= w_rd ? w_rd_val : 32'h0;
    end
  end

  assign bus_rdata      = r_rdata;
  assign bus_rvalid     = r_rvalid;
  assign uart_we        = r_uart_we;
  assign uart_tx_data   = r_tx_data;
  assign uart_negate_rr = r_negate_rr;
  assign uart_baud_max  = r_baud;
  assign irq            = (~w_rx_empty & r_rx_ie) | (w_tx_empty & r_tx_ie);

endmodule
